// File: rtl/pipe_latch_chain.sv
// pipe_latch_chain
//   A chain of STAGES pipeline latches, each carrying a DW-bit payload plus a
//   valid bit. Latch k feeds stage k+1 (0=IF/ID, 1=ID/EX, 2=EX/MEM, 3=MEM/WB).
//   Each latch has its own stall and flush control. A latch that advances
//   while its upstream neighbour holds receives a NOP bubble. Two saturating
//   performance counters track stall cycles and NOPs inserted.
//
// Parameters
//   STAGES : number of latches
//   DW     : payload width per latch
//   NOP    : payload value loaded on flush, bubble or reset
//   CNTW   : width of the saturating performance counters
//
// Ports
//   CLK          in   clock; all state updates on the rising edge
//   nRST         in   synchronous active-low reset
//   in_data      in   payload entering latch 0
//   in_valid     in   in_data is a real instruction
//   in_ready     out  latch 0 accepts in_data this cycle (combinational)
//   stall        in   stall[k] holds latch k and every upstream latch
//   flush        in   flush[k] squashes latch k to NOP / invalid
//   q_data       out  latch contents; latch k at bits [k*DW +: DW]
//   q_valid      out  valid bit per latch
//   stall_cycles out  cycles in which any stall bit was set
//   bubble_count out  NOPs inserted by flush or bubble
//   clr_cnt      in   synchronous clear of both counters (beats increment)
module pipe_latch_chain #(
  parameter int              STAGES = 4,
  parameter int              DW     = 32,
  parameter logic [DW-1:0]   NOP    = '0,
  parameter int              CNTW   = 16
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic [DW-1:0]        in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [STAGES-1:0]    stall,
  input  logic [STAGES-1:0]    flush,
  output logic [STAGES*DW-1:0] q_data,
  output logic [STAGES-1:0]    q_valid,
  output logic [CNTW-1:0]      stall_cycles,
  output logic [CNTW-1:0]      bubble_count,
  input  logic                 clr_cnt
);

  logic [DW-1:0]     r_data [STAGES];
  logic [STAGES-1:0] r_valid;
  logic [CNTW-1:0]   r_stall_cnt;
  logic [CNTW-1:0]   r_bubble_cnt;

  logic [STAGES-1:0] w_hold;       // latch k is frozen by a stall at k or above
  logic [STAGES-1:0] w_nop;        // latch k receives NOP this edge (flush or bubble)
  logic [STAGES-1:0] w_en;         // latch k changes this edge
  logic [DW-1:0]     w_next_data [STAGES];
  logic [STAGES-1:0] w_next_valid;
  logic [CNTW:0]     w_nop_cnt;
  logic [CNTW:0]     w_stall_sum;
  logic [CNTW:0]     w_bubble_sum;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_latch
      // A stall anywhere at or above this latch freezes it.
      assign w_hold[gi] = |(stall >> gi);

      if (gi == 0) begin : g_first
        assign w_nop[gi]        = flush[gi];
        assign w_next_data[gi]  = w_nop[gi] ? NOP : in_data;
        assign w_next_valid[gi] = w_nop[gi] ? 1'b0 : in_valid;
      end else begin : g_rest
        // Bubble: this latch advances while the one feeding it is frozen.
        assign w_nop[gi]        = flush[gi] | (~w_hold[gi] & w_hold[gi-1]);
        assign w_next_data[gi]  = w_nop[gi] ? NOP : r_data[gi-1];
        assign w_next_valid[gi] = w_nop[gi] ? 1'b0 : r_valid[gi-1];
      end

      // Flush overrides hold, so a flushed latch is always written.
      assign w_en[gi] = flush[gi] | ~w_hold[gi];

      assign q_data[gi*DW +: DW] = r_data[gi];
    end
  endgenerate

  assign in_ready = ~w_hold[0] & ~flush[0];
  assign q_valid  = r_valid;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      for (int k = 0; k < STAGES; k++) begin
        r_data[k] <= NOP;
      end
      r_valid <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (w_en[k]) begin
          r_data[k]  <= w_next_data[k];
          r_valid[k] <= w_next_valid[k];
        end
      end
    end
  end

  // Number of latches receiving NOP this edge, 0..STAGES.
  always_comb begin
    w_nop_cnt = '0;
    for (int k = 0; k < STAGES; k++) begin
      w_nop_cnt = w_nop_cnt + (CNTW+1)'(w_nop[k]);
    end
  end

  // One extra bit of headroom detects overflow for saturation.
  assign w_stall_sum  = {1'b0, r_stall_cnt}  + (CNTW+1)'(|stall);
  assign w_bubble_sum = {1'b0, r_bubble_cnt} + w_nop_cnt;

  always_ff @(posedge CLK) begin
    if (!nRST || clr_cnt) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      r_stall_cnt  <= w_stall_sum[CNTW]  ? {CNTW{1'b1}} : w_stall_sum[CNTW-1:0];
      r_bubble_cnt <= w_bubble_sum[CNTW] ? {CNTW{1'b1}} : w_bubble_sum[CNTW-1:0];
    end
  end

  assign stall_cycles = r_stall_cnt;
  assign bubble_count = r_bubble_cnt;

endmodule

// File: tb/tb_pipe_latch_chain.sv
module tb_pipe_latch_chain;

  localparam int          STAGES = 4;
  localparam int          DW     = 32;
  localparam int          CNTW   = 16;
  localparam logic [31:0] NOPV   = 32'h0000_0013;
  localparam int          MAXC   = 65535;

  logic          CLK = 1'b0;
  always #5 CLK = ~CLK;

  // main DUT
  logic          nRST;
  logic [31:0]   in_data;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    stall, flush;
  logic [127:0]  q_data;
  logic [3:0]    q_valid;
  logic [15:0]   stall_cycles, bubble_count;
  logic          clr_cnt;

  // two-stage DUT
  logic          s_nrst;
  logic [7:0]    s_data;
  logic          s_valid;
  logic          s_ready;
  logic [1:0]    s_stall, s_flush;
  logic [15:0]   s_q_data;
  logic [1:0]    s_q_valid;
  logic [15:0]   s_stall_cycles, s_bubble_count;
  logic          s_clr;

  pipe_latch_chain #(.STAGES(STAGES), .DW(DW), .NOP(NOPV), .CNTW(CNTW)) dut (
    .CLK(CLK), .nRST(nRST), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .stall(stall), .flush(flush), .q_data(q_data),
    .q_valid(q_valid), .stall_cycles(stall_cycles), .bubble_count(bubble_count),
    .clr_cnt(clr_cnt)
  );

  pipe_latch_chain #(.STAGES(2), .DW(8), .NOP(8'h00), .CNTW(16)) dut_small (
    .CLK(CLK), .nRST(s_nrst), .in_data(s_data), .in_valid(s_valid),
    .in_ready(s_ready), .stall(s_stall), .flush(s_flush), .q_data(s_q_data),
    .q_valid(s_q_valid), .stall_cycles(s_stall_cycles),
    .bubble_count(s_bubble_count), .clr_cnt(s_clr)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: latch contents as arrays, counters as plain integers.
  logic [31:0] m_data [4];
  bit          m_valid [4];
  int          m_sc, m_bc;

  function automatic void model_edge();
    logic [31:0] nd [4];
    bit          nv [4];
    int          top, nops;
    if (!nRST) begin
      for (int k = 0; k < 4; k++) begin
        m_data[k] = NOPV;
        m_valid[k] = 0;
      end
      m_sc = 0;
      m_bc = 0;
      return;
    end
    // Highest stalled latch: it and everything below it is frozen, and the
    // latch just above it sees a frozen feeder and takes a bubble.
    top = -1;
    for (int k = 0; k < 4; k++) if (stall[k]) top = k;
    nops = 0;
    for (int k = 0; k < 4; k++) begin
      if (flush[k]) begin
        nd[k] = NOPV; nv[k] = 0; nops++;
      end else if (k <= top) begin
        nd[k] = m_data[k]; nv[k] = m_valid[k];
      end else if (top >= 0 && k == top + 1) begin
        nd[k] = NOPV; nv[k] = 0; nops++;
      end else if (k == 0) begin
        nd[k] = in_data; nv[k] = in_valid;
      end else begin
        nd[k] = m_data[k-1]; nv[k] = m_valid[k-1];
      end
    end
    for (int k = 0; k < 4; k++) begin
      m_data[k] = nd[k];
      m_valid[k] = nv[k];
    end
    if (clr_cnt) begin
      m_sc = 0;
      m_bc = 0;
    end else begin
      m_sc = (m_sc + (top >= 0 ? 1 : 0) > MAXC) ? MAXC : m_sc + (top >= 0 ? 1 : 0);
      m_bc = (m_bc + nops > MAXC) ? MAXC : m_bc + nops;
    end
  endfunction

  function automatic logic [127:0] exp_q();
    logic [127:0] r;
    for (int k = 0; k < 4; k++) r[k*32 +: 32] = m_data[k];
    return r;
  endfunction

  function automatic logic [3:0] exp_v();
    logic [3:0] r;
    for (int k = 0; k < 4; k++) r[k] = m_valid[k];
    return r;
  endfunction

  function automatic logic exp_ready();
    return (stall == 4'b0) && !flush[0];
  endfunction

  task automatic tick();
    @(posedge CLK);
    model_edge();
    cyc++;
    #1;
  endtask

  task automatic reset_main();
    nRST = 1'b0; stall = '0; flush = '0; clr_cnt = 1'b0; in_valid = 1'b0;
    tick();
    nRST = 1'b1;
  endtask

  task automatic test_reset();
    nRST = 1'b0; stall = '0; flush = '0; clr_cnt = 1'b0;
    in_data = $urandom; in_valid = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready);
    end
    tick();
    checks++;
    if (q_data !== {4{NOPV}}) begin
      errors++; $display("FAIL reset_qdata got %h exp %h", q_data, {4{NOPV}});
    end
    checks++;
    if (q_valid !== 4'b0) begin
      errors++; $display("FAIL reset_qvalid got %b exp 0000", q_valid);
    end
    checks++;
    if (stall_cycles !== 16'd0 || bubble_count !== 16'd0) begin
      errors++; $display("FAIL reset_counters got %0d/%0d exp 0/0", stall_cycles, bubble_count);
    end
    nRST = 1'b1;
    $display("reset: q_data=%h q_valid=%b", q_data, q_valid);
  endtask

  task automatic test_stream();
    for (int i = 1; i <= 5; i++) begin
      in_data = i; in_valid = 1'b1; stall = '0; flush = '0; clr_cnt = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++; $display("FAIL stream_ready i=%0d got %b exp 1", i, in_ready);
      end
      tick();
      checks++;
      if (q_data !== exp_q() || q_valid !== exp_v()) begin
        errors++; $display("FAIL stream_latches i=%0d got %h/%b exp %h/%b", i, q_data, q_valid, exp_q(), exp_v());
      end
      if (i == 4) begin
        checks++;
        if (q_data[96 +: 32] !== 32'd1 || q_valid !== 4'b1111) begin
          errors++; $display("FAIL stream_latency got %h/%b exp 00000001/1111", q_data[96 +: 32], q_valid);
        end
      end
      $display("stream edge %0d: q_data=%h q_valid=%b", i, q_data, q_valid);
    end
    checks++;
    if (stall_cycles !== 16'd0 || bubble_count !== 16'd0) begin
      errors++; $display("FAIL stream_counters got %0d/%0d exp 0/0", stall_cycles, bubble_count);
    end
  endtask

  task automatic test_stall_bubble();
    reset_main();
    for (int i = 1; i <= 3; i++) begin
      in_data = i; in_valid = 1'b1;
      tick();
    end
    stall = 4'b0010; in_data = 4;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL stall_ready got %b exp 0", in_ready);
    end
    tick();
    checks++;
    if (q_data !== {32'd1, NOPV, 32'd2, 32'd3} || q_valid !== 4'b1011) begin
      errors++; $display("FAIL stall_latches got %h/%b exp %h/1011", q_data, q_valid, {32'd1, NOPV, 32'd2, 32'd3});
    end
    checks++;
    if (stall_cycles !== 16'd1 || bubble_count !== 16'd1) begin
      errors++; $display("FAIL stall_counters got %0d/%0d exp 1/1", stall_cycles, bubble_count);
    end
    stall = '0;
    $display("stall bubble: q_data=%h q_valid=%b", q_data, q_valid);
  endtask

  task automatic test_flush_stall();
    reset_main();
    for (int i = 1; i <= 4; i++) begin
      in_data = i; in_valid = 1'b1;
      tick();
    end
    flush = 4'b0011; stall = 4'b0100; in_data = 5;
    tick();
    checks++;
    if (q_data !== {NOPV, 32'd2, NOPV, NOPV} || q_valid !== 4'b0100) begin
      errors++; $display("FAIL flush_stall_latches got %h/%b exp %h/0100", q_data, q_valid, {NOPV, 32'd2, NOPV, NOPV});
    end
    checks++;
    if (bubble_count !== 16'd3 || stall_cycles !== 16'd1) begin
      errors++; $display("FAIL flush_stall_counters got %0d/%0d exp 3/1", bubble_count, stall_cycles);
    end
    flush = '0; stall = '0;
    $display("flush+stall: q_data=%h q_valid=%b", q_data, q_valid);
  endtask

  task automatic test_random();
    reset_main();
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < 4; k++) begin
        stall[k] = ($urandom_range(0, 7) == 0);
        flush[k] = ($urandom_range(0, 9) == 0);
      end
      in_data  = $urandom;
      in_valid = $urandom_range(0, 1);
      clr_cnt  = ($urandom_range(0, 40) == 0);
      nRST     = ($urandom_range(0, 80) != 0);
      #1;
      checks++;
      if (in_ready !== exp_ready()) begin
        errors++; $display("FAIL rand_ready n=%0d got %b exp %b", n, in_ready, exp_ready());
      end
      tick();
      checks++;
      if (q_data !== exp_q() || q_valid !== exp_v()) begin
        errors++; $display("FAIL rand_latches n=%0d got %h/%b exp %h/%b", n, q_data, q_valid, exp_q(), exp_v());
      end
      checks++;
      if (stall_cycles !== 16'(m_sc) || bubble_count !== 16'(m_bc)) begin
        errors++; $display("FAIL rand_counters n=%0d got %0d/%0d exp %0d/%0d", n, stall_cycles, bubble_count, m_sc, m_bc);
      end
      $display("rand %0d: st=%b fl=%b q_valid=%b sc=%0d bc=%0d", n, stall, flush, q_valid, stall_cycles, bubble_count);
    end
    nRST = 1'b1; stall = '0; flush = '0; clr_cnt = 1'b0;
  endtask

  task automatic test_saturation();
    reset_main();
    stall = 4'b1000; in_valid = 1'b1; in_data = 32'h5555_aaaa;
    repeat (65535) tick();
    checks++;
    if (stall_cycles !== 16'hFFFF) begin
      errors++; $display("FAIL sat_reach got %0d exp 65535", stall_cycles);
    end
    repeat (6) tick();
    checks++;
    if (stall_cycles !== 16'hFFFF || bubble_count !== 16'd0) begin
      errors++; $display("FAIL sat_hold got %0d/%0d exp 65535/0", stall_cycles, bubble_count);
    end
    clr_cnt = 1'b1;
    tick();
    checks++;
    if (stall_cycles !== 16'd0 || bubble_count !== 16'd0) begin
      errors++; $display("FAIL sat_clear got %0d/%0d exp 0/0", stall_cycles, bubble_count);
    end
    clr_cnt = 1'b0; stall = '0;
    $display("saturation: stall_cycles after clear=%0d", stall_cycles);
  endtask

  task automatic test_reset_mid();
    stall = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      in_data = $urandom; in_valid = 1'b1;
      tick();
    end
    nRST = 1'b0;
    tick();
    checks++;
    if (q_data !== {4{NOPV}} || q_valid !== 4'b0 || stall_cycles !== 16'd0 || bubble_count !== 16'd0) begin
      errors++; $display("FAIL midreset_state got %h/%b/%0d/%0d exp all NOP/0", q_data, q_valid, stall_cycles, bubble_count);
    end
    nRST = 1'b1; stall = '0; in_data = 32'hABCD_0123; in_valid = 1'b1;
    tick();
    in_data = 32'h0; in_valid = 1'b0;
    repeat (3) tick();
    checks++;
    if (q_data[96 +: 32] !== 32'hABCD_0123 || q_valid !== 4'b1000) begin
      errors++; $display("FAIL midreset_latency got %h/%b exp abcd0123/1000", q_data[96 +: 32], q_valid);
    end
    $display("mid reset: latch3=%h q_valid=%b", q_data[96 +: 32], q_valid);
  endtask

  task automatic test_small();
    s_nrst = 1'b0;
    tick();
    s_nrst = 1'b1; s_data = 8'h11; s_valid = 1'b1;
    tick();
    s_data = 8'h22;
    tick();
    checks++;
    if (s_q_data !== 16'h1122 || s_q_valid !== 2'b11) begin
      errors++; $display("FAIL small_fill got %h/%b exp 1122/11", s_q_data, s_q_valid);
    end
    s_stall = 2'b10; s_data = 8'h33;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (s_ready !== 1'b0) begin
        errors++; $display("FAIL small_ready i=%0d got %b exp 0", i, s_ready);
      end
      tick();
      checks++;
      if (s_q_data !== 16'h1122 || s_q_valid !== 2'b11) begin
        errors++; $display("FAIL small_frozen i=%0d got %h/%b exp 1122/11", i, s_q_data, s_q_valid);
      end
      $display("small stall %0d: q_data=%h", i, s_q_data);
    end
    checks++;
    if (s_stall_cycles !== 16'd3 || s_bubble_count !== 16'd0) begin
      errors++; $display("FAIL small_counters got %0d/%0d exp 3/0", s_stall_cycles, s_bubble_count);
    end
    s_stall = 2'b00;
    tick();
    checks++;
    if (s_q_data !== 16'h2233) begin
      errors++; $display("FAIL small_resume got %h exp 2233", s_q_data);
    end
  endtask

  initial begin
    nRST = 1'b0; in_data = '0; in_valid = 1'b0; stall = '0; flush = '0; clr_cnt = 1'b0;
    s_nrst = 1'b0; s_data = '0; s_valid = 1'b0; s_stall = '0; s_flush = '0; s_clr = 1'b0;
    test_reset();
    test_stream();
    test_stall_bubble();
    test_flush_stall();
    test_random();
    test_saturation();
    test_reset_mid();
    test_small();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
